// File: rtl/fb_render_scheduler.sv
// Framebuffer write-port scheduler. Clears the back buffer to a background
// colour, then arbitrates the write port round-robin between the bird and
// pipe renderers until both report done, then flags the buffer as swappable.
module fb_render_scheduler #(
  parameter int FB_W    = 320,
  parameter int FB_H    = 240,
  parameter int NUM_PIX = FB_W * FB_H
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic [7:0]  bg_color,
  input  logic        req0,
  input  logic [19:0] addr0,
  input  logic [7:0]  data0,
  input  logic        done0,
  input  logic        req1,
  input  logic [19:0] addr1,
  input  logic [7:0]  data1,
  input  logic        done1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [19:0] addrWrite,
  output logic [7:0]  dataWrite,
  output logic        wr_en,
  output logic        swap_ok,
  output logic        busy,
  output logic [7:0]  dropped_frames
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_DRAW  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [19:0] LAST_ADDR = 20'(NUM_PIX - 1);
  localparam logic [19:0] PIX_LIM   = 20'(NUM_PIX);

  logic [1:0]  state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [7:0]  bg_q, bg_d;
  logic        done0_q, done0_d, done1_q, done1_d;
  logic        ptr_q, ptr_d;
  logic        wr_en_q, wr_en_d;
  logic [19:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        swap_q, swap_d;
  logic        busy_q, busy_d;
  logic [7:0]  drop_q, drop_d;

  logic [19:0] sel_addr;
  logic [7:0]  sel_data;

  // Grants: only in DRAW; on contention the pointer's requester wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == S_DRAW) begin
      gnt0 = req0 & (~req1 | ~ptr_q);
      gnt1 = req1 & (~req0 |  ptr_q);
    end
    sel_addr = gnt0 ? addr0 : addr1;
    sel_data = gnt0 ? data0 : data1;
  end

  // Next-state logic for the frame sequencer and the write port.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bg_d    = bg_q;
    done0_d = done0_q;
    done1_d = done1_q;
    ptr_d   = ptr_q;
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    swap_d  = swap_q;
    drop_d  = drop_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (frame_start) begin
          state_d = S_CLEAR;
          swap_d  = 1'b0;
          bg_d    = bg_color;
          cnt_d   = '0;
          done0_d = 1'b0;
          done1_d = 1'b0;
        end
      end
      S_CLEAR: begin
        wr_en_d = 1'b1;
        addr_d  = cnt_q;
        data_d  = bg_q;
        cnt_d   = cnt_q + 20'd1;
        if (cnt_q == LAST_ADDR) state_d = S_DRAW;
        // Done pulses can arrive early; keep them for the DRAW exit test.
        done0_d = done0_q | done0;
        done1_d = done1_q | done1;
      end
      default: begin // S_DRAW
        done0_d = done0_q | done0;
        done1_d = done1_q | done1;
        if (gnt0 | gnt1) begin
          addr_d  = sel_addr;
          data_d  = sel_data;
          // Out-of-range writes are granted (so the requester moves on) but dropped.
          wr_en_d = (sel_addr < PIX_LIM);
        end
        if (req0 & req1) ptr_d = ~ptr_q;
        // Pending requests are drained before the frame is declared complete.
        if (done0_q & done1_q & ~req0 & ~req1) begin
          state_d = S_DONE;
          swap_d  = 1'b1;
        end
      end
    endcase
    // A flip request while still rendering is an overrun; the frame carries on.
    if (frame_start && (state_q == S_CLEAR || state_q == S_DRAW) && drop_q != 8'hFF)
      drop_d = drop_q + 8'd1;
    busy_d = (state_d == S_CLEAR) || (state_d == S_DRAW);
  end

  // State and output registers; reset forces everything idle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bg_q    <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      ptr_q   <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      swap_q  <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bg_q    <= bg_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      ptr_q   <= ptr_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      swap_q  <= swap_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

  assign wr_en          = wr_en_q;
  assign addrWrite      = addr_q;
  assign dataWrite      = data_q;
  assign swap_ok        = swap_q;
  assign busy           = busy_q;
  assign dropped_frames = drop_q;

endmodule

// File: tb/tb_fb_render_scheduler.sv
// Directed bench for fb_render_scheduler on a 4x2 framebuffer.
module tb_fb_render_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start;
  logic [7:0]  bg_color;
  logic        req0, req1, done0, done1;
  logic [19:0] addr0, addr1;
  logic [7:0]  data0, data1;
  logic        gnt0, gnt1, wr_en, swap_ok, busy;
  logic [19:0] addrWrite;
  logic [7:0]  dataWrite;
  logic [7:0]  dropped_frames;

  int ntests = 0;
  int nfail  = 0;

  fb_render_scheduler #(.FB_W(4), .FB_H(2)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .bg_color(bg_color),
    .req0(req0), .addr0(addr0), .data0(data0), .done0(done0),
    .req1(req1), .addr1(addr1), .data1(data1), .done1(done1),
    .gnt0(gnt0), .gnt1(gnt1), .addrWrite(addrWrite), .dataWrite(dataWrite),
    .wr_en(wr_en), .swap_ok(swap_ok), .busy(busy), .dropped_frames(dropped_frames)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; bg_color = 8'h00;
    req0 = 1'b0; req1 = 1'b0; done0 = 1'b0; done1 = 1'b0;
    addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
    tick(); tick();
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_swap",  32'(swap_ok), 32'd0);
    chk("rst_drop",  32'(dropped_frames), 32'd0);
    chk("rst_addr",  32'(addrWrite), 32'd0);
    chk("rst_gnt",   32'({gnt0, gnt1}), 32'd0);

    // Idle stays idle without frame_start
    rst_n = 1'b1;
    tick(); tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Frame 1: bg 3C; req1 pending during clear; done0 pulse during clear
    bg_color = 8'h3C; frame_start = 1'b1;
    req1 = 1'b1; addr1 = 20'd5; data1 = 8'hAA;
    tick();
    frame_start = 1'b0; bg_color = 8'h00;
    #1;
    chk("clr_busy0", 32'(busy), 32'd1);
    chk("clr_wr0",   32'(wr_en), 32'd0);
    chk("clr_gnt1_0", 32'(gnt1), 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) done0 = 1'b1;
      tick();
      done0 = 1'b0;
      #1;
      chk("clr_wr",   32'(wr_en), 32'd1);
      chk("clr_addr", 32'(addrWrite), 32'(i));
      chk("clr_data", 32'(dataWrite), 32'h3C);
      chk("clr_gnt1", 32'(gnt1), (i == 7) ? 32'd1 : 32'd0);
    end
    chk("draw_busy", 32'(busy), 32'd1);
    chk("draw_swap", 32'(swap_ok), 32'd0);
    chk("draw_gnt0", 32'(gnt0), 32'd0);
    tick();
    chk("held_wr",   32'(wr_en), 32'd1);
    chk("held_addr", 32'(addrWrite), 32'd5);
    chk("held_data", 32'(dataWrite), 32'hAA);

    // Both requesters continuously: alternation starting with requester 0
    req0 = 1'b1; addr0 = 20'd1; data0 = 8'h11;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rr_gnt0", 32'(gnt0), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_gnt1", 32'(gnt1), (k % 2 == 1) ? 32'd1 : 32'd0);
      tick();
      chk("rr_wr",   32'(wr_en), 32'd1);
      chk("rr_addr", 32'(addrWrite), (k % 2 == 0) ? 32'd1 : 32'd5);
      chk("rr_data", 32'(dataWrite), (k % 2 == 0) ? 32'h11 : 32'hAA);
    end

    // Out-of-range address: granted but discarded
    req1 = 1'b0; addr0 = 20'd9; data0 = 8'h99;
    #1;
    chk("oob_gnt0", 32'(gnt0), 32'd1);
    tick();
    chk("oob_wr", 32'(wr_en), 32'd0);
    req0 = 1'b0;
    tick();
    chk("idle_req_wr", 32'(wr_en), 32'd0);
    chk("pre_done_busy", 32'(busy), 32'd1);

    // done1 completes the frame (done0 was latched during clear)
    done1 = 1'b1;
    tick();
    done1 = 1'b0;
    chk("done_swap0", 32'(swap_ok), 32'd0);
    tick();
    chk("done_swap1", 32'(swap_ok), 32'd1);
    chk("done_busy",  32'(busy), 32'd0);
    tick();
    chk("done_hold",  32'(swap_ok), 32'd1);
    chk("done_wr",    32'(wr_en), 32'd0);

    // Frame 2 with a mid-clear overrun
    bg_color = 8'h55; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("f2_swap", 32'(swap_ok), 32'd0);
    chk("f2_busy", 32'(busy), 32'd1);
    tick();
    chk("f2_addr0", 32'(addrWrite), 32'd0);
    chk("f2_data0", 32'(dataWrite), 32'h55);
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("ovr_drop", 32'(dropped_frames), 32'd1);
    chk("ovr_addr2", 32'(addrWrite), 32'd2);
    for (int i = 3; i < 8; i++) tick();
    chk("ovr_wr7",   32'(wr_en), 32'd1);
    chk("ovr_addr7", 32'(addrWrite), 32'd7);
    chk("ovr_swap",  32'(swap_ok), 32'd0);
    tick();
    chk("f2_draw_wr", 32'(wr_en), 32'd0);

    // Mid-DRAW reset: outputs drop without a clock edge
    req0 = 1'b1; addr0 = 20'd2; data0 = 8'h77;
    #1;
    chk("pre_rst_gnt0", 32'(gnt0), 32'd1);
    tick();
    chk("pre_rst_wr", 32'(wr_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_wr",   32'(wr_en), 32'd0);
    chk("arst_gnt",  32'({gnt0, gnt1}), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_swap", 32'(swap_ok), 32'd0);
    chk("arst_drop", 32'(dropped_frames), 32'd0);
    tick();
    rst_n = 1'b1; req0 = 1'b0;
    tick(); tick();
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_wr",   32'(wr_en), 32'd0);

    // Saturation: frame_start held high; the first edge is the accept
    frame_start = 1'b1;
    tick();
    for (int i = 0; i < 254; i++) tick();
    chk("sat_254", 32'(dropped_frames), 32'd254);
    tick();
    chk("sat_255", 32'(dropped_frames), 32'd255);
    for (int i = 0; i < 45; i++) tick();
    chk("sat_hold", 32'(dropped_frames), 32'd255);
    chk("sat_busy", 32'(busy), 32'd1);
    frame_start = 1'b0;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
